// File: rtl/cube_arbiter.sv
// cube_arbiter: round-robin arbiter in front of a shared, fixed-latency cube
// datapath. Issues one operand per cycle and returns results in order, tagged
// with the requester index.
module cube_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 5
) (
    input  logic                       clock,
    input  logic                       reset_done,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     req_num,
    output logic [N_REQ-1:0]           grant,
    output logic                       cube_valid,
    output logic [WIDTH-1:0]           cube_num,
    input  logic [WIDTH-1:0]           cube_result,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       idle,
    output logic [15:0]                issue_count
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             cube_valid_q, cube_valid_d;
    logic [WIDTH-1:0] cube_num_q, cube_num_d;
    logic [ID_W-1:0]  issue_id_q, issue_id_d;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [ID_W-1:0]  tag_id_q [LATENCY];
    logic [ID_W-1:0]  tag_id_d [LATENCY];
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]      issue_count_q, issue_count_d;

    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [WIDTH-1:0] grant_num;
    logic             pipe_empty;

    // Round-robin pick starting at ptr; only while running and enabled.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant_num = '0;
        if (state_q == ST_RUN && enable) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = ptr_q + ID_W'(k);
                if (!grant_any && req[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                grant_num = req_num[i*WIDTH +: WIDTH];
            end
        end
    end

    // Issue register, tag pipeline, response capture and counters.
    always_comb begin
        ptr_d         = grant_any ? ID_W'(grant_idx + 1'b1) : ptr_q;
        cube_valid_d  = grant_any;
        cube_num_d    = grant_any ? grant_num : cube_num_q;
        issue_id_d    = grant_any ? grant_idx : issue_id_q;
        issue_count_d = grant_any ? issue_count_q + 16'd1 : issue_count_q;

        // Stage 0 follows the issue strobe so the last stage lines up with
        // cube_result LATENCY cycles after cube_num was presented.
        tag_v_d[0]  = cube_valid_q;
        tag_id_d[0] = issue_id_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end

        rsp_valid_d = tag_v_q[LATENCY-1];
        rsp_id_d    = tag_v_q[LATENCY-1] ? tag_id_q[LATENCY-1] : rsp_id_q;
        rsp_data_d  = tag_v_q[LATENCY-1] ? cube_result : rsp_data_q;
    end

    assign pipe_empty = !cube_valid_q && !(|tag_v_q);

    // Control FSM: DRAIN lets in-flight work finish before returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)          state_d = ST_RUN;
                else if (pipe_empty) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset_done) begin
        if (reset_done) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cube_valid_q  <= 1'b0;
            cube_num_q    <= '0;
            issue_id_q    <= '0;
            tag_v_q       <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cube_valid_q  <= cube_valid_d;
            cube_num_q    <= cube_num_d;
            issue_id_q    <= issue_id_d;
            tag_v_q       <= tag_v_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign cube_valid  = cube_valid_q;
    assign cube_num    = cube_num_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign idle        = (state_q == ST_IDLE);
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_cube_arbiter.sv
// tb_cube_arbiter: directed and random stimulus for cube_arbiter, checked
// against a transaction-level model (expected-response queue with due cycles).
module tb_cube_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 5;

    logic           clock;
    logic           reset_done;
    logic           enable;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_num;
    logic [N-1:0]   grant;
    logic           cube_valid;
    logic [W-1:0]   cube_num;
    logic [W-1:0]   cube_result;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           idle;
    logic [15:0]    issue_count;

    cube_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clock(clock), .reset_done(reset_done), .enable(enable), .req(req),
        .req_num(req_num), .grant(grant), .cube_valid(cube_valid),
        .cube_num(cube_num), .cube_result(cube_result), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle),
        .issue_count(issue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared cube datapath: LATENCY-cycle pipeline, result mod 2^32.
    logic [W-1:0] dp [L];
    always @(posedge clock) begin
        dp[0] <= cube_num * cube_num * cube_num;
        for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
    end
    assign cube_result = dp[L-1];

    // Reference model state.
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    typedef struct { int due; int id; logic [W-1:0] data; } rsp_t;

    mstate_t      mst;
    int           mptr;
    logic [15:0]  mcnt;
    logic         exp_cv;
    logic [W-1:0] last_num;
    logic [1:0]   last_id;
    logic [W-1:0] last_data;
    rsp_t         q[$];
    int           cyc;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic set_num(input int i, input logic [W-1:0] v);
        req_num[i*W +: W] = v;
    endtask

    task automatic model_reset();
        mst = M_IDLE; mptr = 0; mcnt = '0; exp_cv = 1'b0;
        last_num = '0; last_id = '0; last_data = '0;
        q.delete();
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        logic [N-1:0] eg;
        int           gi;
        bit           acc;
        bit           exp_rv;
        bit           empty;
        logic [W-1:0] n;
        logic [W-1:0] c3;
        rsp_t         r;
        #1;
        exp_rv = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv    = 1'b1;
            last_id   = 2'(q[0].id);
            last_data = q[0].data;
            void'(q.pop_front());
        end
        eg = '0; gi = 0; acc = 1'b0;
        if (mst == M_RUN && enable) begin
            for (int k = 0; k < N; k++) begin
                if (!acc && req[(mptr + k) % N]) begin
                    acc = 1'b1;
                    gi  = (mptr + k) % N;
                end
            end
        end
        if (acc) eg[gi] = 1'b1;

        chk("grant",       grant,       eg);
        chk("cube_valid",  cube_valid,  exp_cv);
        chk("cube_num",    cube_num,    last_num);
        chk("rsp_valid",   rsp_valid,   exp_rv);
        chk("rsp_id",      rsp_id,      last_id);
        chk("rsp_data",    rsp_data,    last_data);
        chk("idle",        idle,        mst == M_IDLE);
        chk("issue_count", issue_count, mcnt);

        empty = (q.size() == 0);
        if (acc) begin
            n      = req_num[gi*W +: W];
            c3     = n * n * n;
            r.due  = cyc + 2 + L;
            r.id   = gi;
            r.data = c3;
            q.push_back(r);
            mptr     = (gi + 1) % N;
            mcnt     = mcnt + 16'd1;
            last_num = n;
        end
        exp_cv = acc;
        case (mst)
            M_IDLE:  if (enable) mst = M_RUN;
            M_RUN:   if (!enable) mst = M_DRAIN;
            M_DRAIN: if (enable) mst = M_RUN; else if (empty) mst = M_IDLE;
            default: mst = M_IDLE;
        endcase
        cyc++;
        @(negedge clock);
    endtask

    task automatic ticks(input int count);
        for (int i = 0; i < count; i++) tick();
    endtask

    // Asynchronous reset asserted mid-cycle; reset values checked while held.
    task automatic do_reset();
        reset_done = 1'b1;
        enable     = 1'b0;
        req        = '0;
        #1;
        chk("rst_grant",      grant,       4'b0000);
        chk("rst_cube_valid", cube_valid,  1'b0);
        chk("rst_cube_num",   cube_num,    32'd0);
        chk("rst_rsp_valid",  rsp_valid,   1'b0);
        chk("rst_rsp_id",     rsp_id,      2'd0);
        chk("rst_rsp_data",   rsp_data,    32'd0);
        chk("rst_idle",       idle,        1'b1);
        chk("rst_issue_cnt",  issue_count, 16'd0);
        model_reset();
        @(negedge clock);
        reset_done = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset_done = 1'b1; enable = 1'b0; req = '0; req_num = '0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Single request, num 3 -> 27 seven cycles after acceptance.
        enable = 1'b1;
        tick();
        req = 4'b0001; set_num(0, 32'd3);
        tick();
        req = 4'b0000;
        ticks(6);
        #1;
        chk("r033_rsp_valid", rsp_valid, 1'b1);
        chk("r033_rsp_data",  rsp_data,  32'd27);
        tick();
        ticks(2);

        // All four requesting: rotation 0,1,2,3,0,...
        req = 4'b1111;
        set_num(0, 32'd1); set_num(1, 32'd2); set_num(2, 32'd3); set_num(3, 32'd4);
        ticks(8);
        req = 4'b0000;
        ticks(9);

        // Grant to 2 moves the pointer to 3; then 4'b1010 -> 3 then 1.
        req = 4'b0100;
        tick();
        req = 4'b1010;
        #1;
        chk("r035_first", grant, 4'b1000);
        tick();
        #1;
        chk("r035_second", grant, 4'b0010);
        tick();
        req = 4'b0000;
        ticks(9);

        // Three accepted, then enable low: drain to idle, no further grants.
        req = 4'b1111;
        ticks(3);
        enable = 1'b0;
        ticks(14);
        #1;
        chk("r036_idle", idle, 1'b1);
        tick();

        // Reset with three in flight: none of them may respond.
        enable = 1'b1;
        tick();
        ticks(3);
        do_reset();
        ticks(12);

        // Wrap-around operands.
        enable = 1'b1;
        tick();
        req = 4'b0001; set_num(0, 32'h0000_0800);
        tick();
        set_num(0, 32'hFFFF_FFFF);
        tick();
        req = 4'b0000;
        ticks(9);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            req    = 4'($urandom);
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 7))
                    0:       set_num(j, 32'hFFFF_FFFF);
                    1:       set_num(j, 32'h0000_0800);
                    2:       set_num(j, 32'd0);
                    default: set_num(j, $urandom);
                endcase
            end
            tick();
        end
        enable = 1'b0; req = '0;
        ticks(12);

        // 65536 acceptances wrap issue_count to zero.
        do_reset();
        enable = 1'b1;
        tick();
        req = 4'b0001; set_num(0, 32'd5);
        ticks(65536);
        req = 4'b0000;
        #1;
        chk("r038_wrap", issue_count, 16'd0);
        tick();
        enable = 1'b0;
        ticks(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cube_arbiter.md
CUBE_ARBITER -- requirements
Module: cube_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (power of 2, >=2).
REQ-002 Parameter WIDTH, default 32, operand/result width.
REQ-003 Parameter LATENCY, default 5, cycles from cube_num/cube_valid driven to matching cube_result.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset_done  input  1  reset, asynchronous, active-high.
REQ-006 Port enable  input  1  allows new grants when high.
REQ-007 Port req  input  N_REQ  per-requester request.
REQ-008 Port req_num  input  N_REQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 Port grant  output  N_REQ  one-hot-or-zero grant, combinational.
REQ-010 Port cube_valid  output  1  registered issue strobe to shared cube datapath.
REQ-011 Port cube_num  output  WIDTH  registered operand to datapath.
REQ-012 Port cube_result  input  WIDTH  datapath result, unsigned num^3 mod 2^WIDTH.
REQ-013 Port rsp_valid  output  1  registered response strobe.
REQ-014 Port rsp_id  output  log2(N_REQ)  requester index of response.
REQ-015 Port rsp_data  output  WIDTH  cube of that requester's operand.
REQ-016 Port idle  output  1  high in IDLE state.
REQ-017 Port issue_count  output  16  accepted-request count.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->RUN when enable=1; DRAIN->IDLE when enable=0 and tag pipeline empty.
REQ-019 grant nonzero only when state=RUN and enable=1; at most one bit set; never set for a requester with req=0.
REQ-020 Round-robin: search starts at pointer ptr, ascending with wrap; after grant to i, ptr=(i+1) mod N_REQ; ptr unchanged in cycles without grant.
REQ-021 Acceptance: cycle c where req[i]&grant[i]; one acceptance max per cycle; no backpressure on responses.
REQ-022 Accepted operand drives cube_num with cube_valid=1 in cycle c+1; cube_valid=0 and cube_num holds its last value otherwise.
REQ-023 Tag pipeline of depth LATENCY carries {valid, id} aligned with datapath; cube_result sampled in cycle c+1+LATENCY.
REQ-024 rsp_valid=1, rsp_id=i, rsp_data=cube_result in cycle c+2+LATENCY; rsp_valid low otherwise; rsp_data/rsp_id hold when rsp_valid=0.
REQ-025 Responses return in acceptance order; back-to-back acceptances yield back-to-back responses.
REQ-026 issue_count increments by 1 per acceptance, wraps 0xFFFF->0x0000.
REQ-027 Tag pipeline empty = no valid tag in any stage and no pending cube_valid; DRAIN exit evaluated on that condition.
REQ-028 enable dropping in cycle c blocks grant in cycle c; all in-flight requests still complete.
REQ-029 No arithmetic performed in block; results passed unmodified, wrap-around owned by datapath.

Reset
REQ-030 reset_done=1 asynchronously forces: state IDLE, idle=1, ptr=0, tags cleared, cube_valid=0, cube_num=0, rsp_valid=0, rsp_id=0, rsp_data=0, issue_count=0.
REQ-031 Reset mid-operation discards all in-flight requests; no rsp_valid for them after release.
REQ-032 First grant possible in the cycle after the first edge where enable=1 is sampled after reset release.

Verification (bench supplies a LATENCY-cycle cube model)
REQ-033 Reset, enable=1, req=4'b0001, num0=3 -> grant=4'b0001; cube_num=3 next cycle; rsp_valid, rsp_id=0, rsp_data=27 at acceptance+LATENCY+2 = +7 cycles.
REQ-034 req=4'b1111 held, nums 1,2,3,4 -> grants 0,1,2,3,0,...; responses ids 0,1,2,3 consecutive, data 1,8,27,64.
REQ-035 ptr=3 after grant to 2, then req=4'b1010 -> grant=4'b1000, next cycle grant=4'b0010.
REQ-036 Three accepted, enable=0 -> state DRAIN, grant=0, three responses delivered, idle=1 one cycle after last tag leaves pipeline.
REQ-037 Reset asserted with 3 in flight -> no rsp_valid afterwards, issue_count=0, idle=1.
REQ-038 num=0x800 -> rsp_data=0x00000000; num=0xFFFFFFFF -> rsp_data=0xFFFFFFFF; 65536 acceptances -> issue_count wraps to 0.
